exe_stage_pipe: RTL and testbench
=================================

Name: exe_stage_pipe

Overview:
- Parametrised, registered execute stage for the pipelined processor; the successor to the single-cycle combinational EXE stage.
- Selects operands (forwarded bus / constant 1 / immediate) and performs ALU ops plus multiply.
- Multiply runs either combinationally or as an iterative shift-add over WIDTH cycles.
- Results leave through a valid/ready output register, so hazard logic can stall upstream while a multiply is in flight.

Parameters:
- WIDTH, 16, datapath width in bits; must be ≥4 and a power of 2.
- MUL_ITER, 1, 1 = iterative multiply (WIDTH cycles); 0 = single-cycle combinational multiply.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of in-flight and held work.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  3  operation code (see package).
- alu_src1  in  1  0: A = bus1; 1: A = constant 1.
- alu_src2  in  1  0: B = bus2; 1: B = imm.
- bus1  in  WIDTH  forwarded operand 1.
- bus2  in  WIDTH  forwarded operand 2.
- imm  in  WIDTH  sign-extended immediate.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- alu_out  out  WIDTH  result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result MSB.
- flag_c  out  1  ADD carry-out / SUB borrow (A < B unsigned); 0 for all other ops.
- busy  out  1  iterative multiply in progress.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_out=0, flags=0, busy=0, FSM=IDLE, multiplier registers cleared. Reset mid-multiply abandons the multiply; no result is produced.
- Op codes:
  - 000 AND, 001 ADD, 010 SUB (A−B), 011 SLL, 100 SRL, 101 SRA, 110 OR, 111 MUL.
  - MUL returns the low WIDTH bits of A×B (unsigned).
  - Shift amount = B[log2(WIDTH)−1:0]; upper bits of B are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept occurs when in_valid && in_ready at a rising edge.
- Single-cycle ops (all except MUL, and MUL when MUL_ITER=0):
  - alu_out/flags/out_valid load on the accept edge; result visible the next cycle (latency 1).
  - Back-to-back accepts allowed every cycle while out_ready=1.
- Iterative MUL (MUL_ITER=1), FSM IDLE→MUL→IDLE:
  - Accept edge: latch A, B, clear accumulator, count=WIDTH, busy=1, out_valid=0.
  - Each MUL-state edge: if multiplier LSB set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count−−.
  - On the edge where count reaches 0: write acc to alu_out, set flags (flag_c=0), out_valid=1, busy=0, state=IDLE.
  - out_valid is first high exactly WIDTH cycles after the accept cycle.
  - in_ready stays 0 throughout MUL.
- Holding:
  - out_valid && !out_ready → alu_out/flags/out_valid hold unchanged.
  - out_valid && out_ready with no new accept → out_valid clears next edge.
- Flush (sync):
  - Next edge: out_valid=0, FSM→IDLE, busy=0; in-flight multiply discarded; alu_out keeps its stale value.
  - in_ready=0 during the flush cycle, so flush wins over a simultaneous in_valid.
- Overflow: ADD/SUB/MUL wrap modulo 2^WIDTH; no trap.
- Inputs are sampled only on the accept edge; bus changes during MUL have no effect.

Decomposition:
- exe_pkg:
  - op-code localparams (OP_AND…OP_MUL);
  - FSM state encoding (ST_IDLE, ST_MUL);
  - shift-amount width function clog2.
- Sub-module exe_alu_comb (combinational):
  - computes all single-cycle results and flags from A, B, op;
  - includes the combinational multiply used when MUL_ITER=0.
- Top level holds operand muxes, handshake, FSM, iterative multiplier, and output register.

Test Plan (WIDTH=16, MUL_ITER=1 unless noted):
- ADD bus1=0x7FFF, bus2=0x0001 → next cycle alu_out=0x8000, flag_n=1, flag_z=0, flag_c=0, out_valid=1.
- SUB bus1=5, bus2=7; then alu_src1=1, alu_src2=1, imm=0x0004, ADD:
  - SUB → alu_out=0xFFFE, flag_c=1;
  - ADD → alu_out=0x0005.
- MUL bus1=0x0123, bus2=0x0010 → busy=1, in_ready=0 for 16 cycles; out_valid first high 16 cycles after accept, alu_out=0x1230. Repeat with MUL_ITER=0 → same result with latency 1.
- Back-pressure: ADD accepted with out_ready=0 for 3 cycles → alu_out stable, in_ready=0. Raise out_ready → in_ready=1, next op accepted, result replaces held one.
- Flush after 5 MUL cycles → next cycle busy=0, out_valid=0, in_ready=1. Following AND 0xF0F0 & 0x0FF0 → 0x00F0.
- Reset mid-MUL (rst_n low for 1 cycle, asynchronously) → out_valid=0, alu_out=0, busy=0 immediately. No stale product appears afterwards.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared constants for the pipelined execute stage.
// Op codes, multiply FSM states and a width helper.
package exe_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/exe_alu_comb.sv
// exe_alu_comb: single-cycle ALU results and flags.
// Also holds the combinational multiplier.
module exe_alu_comb
  import exe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  localparam int SW = clog2(WIDTH);

  logic [SW-1:0] sh;
  logic [WIDTH:0] sum;

  assign sh = b[SW-1:0];

  // Select the result for the current op code
  always_comb begin
    res    = '0;
    flag_c = 1'b0;
    sum    = '0;
    unique case (op)
      OP_AND: res = a & b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        res    = sum[WIDTH-1:0];
        flag_c = sum[WIDTH];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        res    = sum[WIDTH-1:0];
        flag_c = sum[WIDTH];
      end
      OP_SLL: res = a << sh;
      OP_SRL: res = a >> sh;
      OP_SRA: res = $signed(a) >>> sh;
      OP_OR:  res = a | b;
      OP_MUL: res = a * b;
      default: res = '0;
    endcase
  end

  assign flag_z = (res == '0);
  assign flag_n = res[WIDTH-1];

endmodule

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered execute stage with
// valid/ready output and optional iterative multiply.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit MUL_ITER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic             alu_src1,
  input  logic             alu_src2,
  input  logic [WIDTH-1:0] bus1,
  input  logic [WIDTH-1:0] bus2,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             busy
);

  localparam int CW = clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  state_t state;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] c_res;
  logic [CW-1:0]    count;
  logic             c_z;
  logic             c_n;
  logic             c_c;
  logic             accept;
  logic             start_mul;

  assign op_a = alu_src1 ? WIDTH'(1) : bus1;
  assign op_b = alu_src2 ? imm : bus2;

  assign in_ready = (state == ST_IDLE)
                  && (!out_valid || out_ready)
                  && !flush;
  assign accept    = in_valid && in_ready;
  assign start_mul = MUL_ITER && (alu_op == OP_MUL);
  assign acc_nxt   = mplier[0] ? acc + mcand : acc;

  exe_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op),
    .res    (c_res),
    .flag_z (c_z),
    .flag_n (c_n),
    .flag_c (c_c)
  );

  // Handshake, shift-add multiply FSM and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            alu_out   <= acc_nxt;
            flag_z    <= (acc_nxt == '0);
            flag_n    <= acc_nxt[WIDTH-1];
            flag_c    <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (accept && start_mul) begin
            mcand     <= op_a;
            mplier    <= op_b;
            acc       <= '0;
            count     <= CNT_INIT;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            state     <= ST_MUL;
          end else if (accept) begin
            alu_out   <= c_res;
            flag_z    <= c_z;
            flag_n    <= c_n;
            flag_c    <= c_c;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: randomized and directed bench
// against a cycle-level behavioural model.
module tb_exe_stage_pipe;
  import exe_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic alu_src1 = 1'b0;
  logic alu_src2 = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] alu_op = 3'd0;
  logic [W-1:0] bus1 = '0;
  logic [W-1:0] bus2 = '0;
  logic [W-1:0] imm = '0;

  logic rdy1, ov1, z1, n1, c1, busy1;
  logic rdy0, ov0, z0, n0, c0, busy0;
  logic [W-1:0] out1, out0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exe_stage_pipe #(.WIDTH(W), .MUL_ITER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .alu_op(alu_op), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .bus1(bus1),
    .bus2(bus2), .imm(imm),
    .out_valid(ov1), .out_ready(out_ready),
    .alu_out(out1), .flag_z(z1), .flag_n(n1),
    .flag_c(c1), .busy(busy1)
  );

  exe_stage_pipe #(.WIDTH(W), .MUL_ITER(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .alu_op(alu_op), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .bus1(bus1),
    .bus2(bus2), .imm(imm),
    .out_valid(ov0), .out_ready(out_ready),
    .alu_out(out0), .flag_z(z0), .flag_n(n0),
    .flag_c(c0), .busy(busy0)
  );

  typedef struct packed {
    logic        ov;
    logic [5:0]  left;
    logic [15:0] res;
    logic [15:0] pend;
    logic        z;
    logic        n;
    logic        c;
  } m_t;

  m_t m1 = '0;
  m_t m0 = '0;

  // returns {carry, result} using plain integer arithmetic
  function automatic logic [16:0] ref_op(
    logic [2:0] op, longint a, longint b);
    longint r;
    longint sa;
    bit c;
    int sh;
    r = 0;
    c = 1'b0;
    sh = int'(b % 16);
    case (op)
      3'd0: r = a & b;
      3'd1: begin r = a + b; c = (r > 65535); end
      3'd2: begin c = (a < b); r = a - b + 65536; end
      3'd3: r = a << sh;
      3'd4: r = a >> sh;
      3'd5: begin
        sa = (a >= 32768) ? a - 65536 : a;
        r = sa >>> sh;
      end
      3'd6: r = a | b;
      default: r = a * b;
    endcase
    return {c, 16'(r & 65535)};
  endfunction

  function automatic bit exp_rdy(m_t m);
    return (m.left == 0) && (!m.ov || out_ready) && !flush;
  endfunction

  function automatic m_t step(m_t m, bit iter);
    m_t x;
    logic [16:0] cr;
    longint a;
    longint b;
    x = m;
    a = alu_src1 ? 64'd1 : 64'(bus1);
    b = alu_src2 ? 64'(imm) : 64'(bus2);
    if (flush) begin
      x.ov = 1'b0;
      x.left = '0;
    end else if (m.left != 0) begin
      x.left = m.left - 6'd1;
      if (x.left == 0) begin
        x.ov = 1'b1;
        x.res = m.pend;
        x.z = (m.pend == 0);
        x.n = m.pend[15];
        x.c = 1'b0;
      end
    end else if (in_valid && exp_rdy(m)) begin
      cr = ref_op(alu_op, a, b);
      if (iter && alu_op == 3'd7) begin
        x.left = 6'd16;
        x.ov = 1'b0;
        x.pend = cr[15:0];
      end else begin
        x.ov = 1'b1;
        x.res = cr[15:0];
        x.c = cr[16];
        x.z = (cr[15:0] == 0);
        x.n = cr[15];
      end
    end else if (out_ready) begin
      x.ov = 1'b0;
    end
    return x;
  endfunction

  // model advances on the same edges as the DUTs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = '0;
      m0 = '0;
    end else begin
      m1 = step(m1, 1'b1);
      m0 = step(m0, 1'b0);
    end
  end

  task automatic cmp(string nm, m_t m, logic rdy,
    logic ov, logic bsy, logic [15:0] o,
    logic z, logic n, logic c);
    logic [21:0] got;
    logic [21:0] exp;
    got = {rdy, ov, bsy, o, z, n, c};
    exp = {exp_rdy(m), m.ov, (m.left != 0),
           m.res, m.z, m.n, m.c};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t rdy/ov/busy/out/z/n/c got %b/%b/%b/%h/%b%b%b exp %b/%b/%b/%h/%b%b%b",
        nm, $time, got[21], got[20], got[19], got[18:3],
        got[2], got[1], got[0], exp[21], exp[20],
        exp[19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // compare both DUTs with the model every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("iter", m1, rdy1, ov1, busy1, out1, z1, n1, c1);
      cmp("comb", m0, rdy0, ov0, busy0, out0, z0, n0, c0);
    end
  end

  task automatic chk(string nm, longint got, longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(logic [2:0] op, logic s1, logic s2,
    logic [15:0] b1, logic [15:0] b2, logic [15:0] im);
    alu_op = op;
    alu_src1 = s1;
    alu_src2 = s2;
    bus1 = b1;
    bus2 = b2;
    imm = im;
  endtask

  initial begin : main
    int n;
    bit seen;
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_ov", ov1, 0);
    chk("rst_out", out1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_rdy", rdy1, 1);

    drv(OP_ADD, 0, 0, 16'h7FFF, 16'h0001, 0);
    in_valid = 1'b1;
    cyc();
    chk("add_out", out1, 16'h8000);
    chk("add_n", n1, 1);
    chk("add_z", z1, 0);
    chk("add_c", c1, 0);
    chk("add_ov", ov1, 1);

    drv(OP_SUB, 0, 0, 16'd5, 16'd7, 0);
    cyc();
    chk("sub_out", out1, 16'hFFFE);
    chk("sub_c", c1, 1);
    drv(OP_ADD, 1, 1, 16'h1234, 16'h5678, 16'h0004);
    cyc();
    in_valid = 1'b0;
    chk("addi_out", out1, 16'h0005);
    cyc();

    drv(OP_MUL, 0, 0, 16'h0123, 16'h0010, 0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("mulc_out", out0, 16'h1230);
    chk("mulc_ov", ov0, 1);
    n = 0;
    while (!ov1 && n < 40) begin
      chk("mul_busy", busy1, 1);
      chk("mul_rdy", rdy1, 0);
      bus1 = 16'($urandom);
      bus2 = 16'($urandom);
      cyc();
      n++;
    end
    chk("mul_lat", n, 16);
    chk("mul_out", out1, 16'h1230);
    chk("mul_busy_end", busy1, 0);
    cyc();

    out_ready = 1'b0;
    drv(OP_ADD, 0, 0, 16'd2, 16'd3, 0);
    in_valid = 1'b1;
    cyc();
    chk("bp_ov", ov1, 1);
    chk("bp_out", out1, 16'h0005);
    drv(OP_ADD, 0, 0, 16'h0010, 16'h0020, 0);
    repeat (3) begin
      cyc();
      chk("bp_hold", out1, 16'h0005);
      chk("bp_rdy", rdy1, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", rdy1, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_new", out1, 16'h0030);
    cyc();

    drv(OP_MUL, 0, 0, 16'h00FF, 16'h0101, 0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    flush = 1'b1;
    drv(OP_AND, 0, 0, 16'hF0F0, 16'h0FF0, 0);
    in_valid = 1'b1;
    #1;
    chk("fl_rdy", rdy1, 0);
    cyc();
    flush = 1'b0;
    chk("fl_busy", busy1, 0);
    chk("fl_ov", ov1, 0);
    chk("fl_stale", out1, 16'h0030);
    #1;
    chk("fl_rdy_after", rdy1, 1);
    cyc();
    in_valid = 1'b0;
    chk("and_out", out1, 16'h00F0);
    chk("and_ov", ov1, 1);
    cyc();

    drv(OP_MUL, 0, 0, 16'h0123, 16'h0010, 0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("ar_ov", ov1, 0);
    chk("ar_out", out1, 0);
    chk("ar_busy", busy1, 0);
    cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      cyc();
      seen |= ov1;
    end
    chk("ar_no_stale", seen, 0);

    repeat (3000) begin
      cyc();
      in_valid = ($urandom % 4) != 0;
      alu_op = 3'($urandom);
      alu_src1 = ($urandom % 4) == 0;
      alu_src2 = ($urandom % 3) == 0;
      bus1 = 16'($urandom);
      bus2 = 16'($urandom);
      imm = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 40) == 0;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
